// File: rtl/pipe_stage_reg_pkg.sv
// rtl/pipe_stage_reg_pkg.sv - shared stage types for the elastic pipeline register
package PipelineReg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } stage_state_e;

  // EX/MEM payload; instantiate with WIDTH = $bits(PipelineReg::EX_STATE)
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] alu_result;
    logic [31:0] rs2_data;
    logic [4:0]  rd;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
  } EX_STATE;

endpackage

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - elastic valid/ready stage register with flush and optional skid entry
module pipe_stage_reg
  import PipelineReg::*;
#(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter bit               SKID        = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  stage_state_e     state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q;
  logic             push, pop;

  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;
  assign count     = state_q;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    if (flush) begin
      state_d = EMPTY;
      main_d  = RESET_VALUE;
    end else begin
      case (state_q)
        EMPTY: begin
          if (push) begin
            main_d  = in_data;
            state_d = HALF;
          end
        end
        HALF: begin
          if (push && pop) begin
            main_d = in_data;
          end else if (push) begin
            state_d = FULL;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            main_d  = skid_q;
            state_d = HALF;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
      main_q  <= RESET_VALUE;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
    end
  end

  generate
    if (SKID) begin : g_skid
      logic [WIDTH-1:0] skid_d;
      logic             ready_q;

      always_comb begin
        skid_d = skid_q;
        if (flush) begin
          skid_d = RESET_VALUE;
        end else if (state_q == HALF && push && !pop) begin
          skid_d = in_data;
        end
      end

      // in_ready looks one state ahead so it never depends on out_ready combinationally
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          skid_q  <= RESET_VALUE;
          ready_q <= 1'b1;
        end else begin
          skid_q  <= skid_d;
          ready_q <= (state_d != FULL);
        end
      end

      assign in_ready = ready_q;
    end else begin : g_comb
      assign skid_q   = RESET_VALUE;
      assign in_ready = !out_valid || out_ready;
    end
  endgenerate

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - directed and scoreboard bench for pipe_stage_reg, both SKID settings
module tb_pipe_stage_reg;

  localparam logic [31:0] RV = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        reset;
  logic        s_flush, s_in_valid, s_in_ready, s_out_valid, s_out_ready;
  logic [31:0] s_in_data, s_out_data;
  logic [1:0]  s_count;
  logic        n_flush, n_in_valid, n_in_ready, n_out_valid, n_out_ready;
  logic [31:0] n_in_data, n_out_data;
  logic [1:0]  n_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.WIDTH(32), .RESET_VALUE(RV), .SKID(1'b1)) u_skid (
    .clk(clk), .reset(reset), .flush(s_flush),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
    .count(s_count)
  );

  pipe_stage_reg #(.WIDTH(32), .RESET_VALUE(RV), .SKID(1'b0)) u_noskid (
    .clk(clk), .reset(reset), .flush(n_flush),
    .in_valid(n_in_valid), .in_ready(n_in_ready), .in_data(n_in_data),
    .out_valid(n_out_valid), .out_ready(n_out_ready), .out_data(n_out_data),
    .count(n_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    s_flush = 0; s_in_valid = 0; s_in_data = '0; s_out_ready = 0;
    n_flush = 0; n_in_valid = 0; n_in_data = '0; n_out_ready = 0;
    tick(); tick();
    total++; if (s_out_valid !== 1'b0) begin bad++; $display("FAIL rst_s_valid: got %b want 0", s_out_valid); end
    total++; if (s_count !== 2'd0) begin bad++; $display("FAIL rst_s_count: got %0d want 0", s_count); end
    total++; if (s_out_data !== RV) begin bad++; $display("FAIL rst_s_data: got %h want %h", s_out_data, RV); end
    total++; if (s_in_ready !== 1'b1) begin bad++; $display("FAIL rst_s_ready: got %b want 1", s_in_ready); end
    total++; if (n_in_ready !== 1'b1) begin bad++; $display("FAIL rst_n_ready: got %b want 1", n_in_ready); end
    total++; if (n_out_data !== RV) begin bad++; $display("FAIL rst_n_data: got %h want %h", n_out_data, RV); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_stream();
    s_out_ready = 1; n_out_ready = 1;
    total++; if (s_count !== 2'd0) begin bad++; $display("FAIL str_start_count: got %0d want 0", s_count); end
    for (int i = 1; i <= 8; i++) begin
      s_in_valid = 1; s_in_data = 32'(i);
      n_in_valid = 1; n_in_data = 32'(i);
      tick();
      total++; if (s_out_valid !== 1'b1 || s_out_data !== 32'(i)) begin bad++; $display("FAIL str_s_data%0d: got %b/%h want 1/%h", i, s_out_valid, s_out_data, i); end
      total++; if (s_count !== 2'd1 || s_in_ready !== 1'b1) begin bad++; $display("FAIL str_s_cnt%0d: got %0d/%b want 1/1", i, s_count, s_in_ready); end
      total++; if (n_out_valid !== 1'b1 || n_out_data !== 32'(i)) begin bad++; $display("FAIL str_n_data%0d: got %b/%h want 1/%h", i, n_out_valid, n_out_data, i); end
      total++; if (n_count !== 2'd1) begin bad++; $display("FAIL str_n_cnt%0d: got %0d want 1", i, n_count); end
    end
    s_in_valid = 0; n_in_valid = 0;
    tick();
    total++; if (s_count !== 2'd0 || s_out_valid !== 1'b0) begin bad++; $display("FAIL str_s_drain: got %0d/%b want 0/0", s_count, s_out_valid); end
    total++; if (n_count !== 2'd0) begin bad++; $display("FAIL str_n_drain: got %0d want 0", n_count); end
  endtask

  task automatic test_bp_skid();
    s_out_ready = 0;
    s_in_valid = 1; s_in_data = 32'hA;
    tick();
    total++; if (s_count !== 2'd1 || s_in_ready !== 1'b1) begin bad++; $display("FAIL bps_half: got %0d/%b want 1/1", s_count, s_in_ready); end
    s_in_data = 32'hB;
    tick();
    total++; if (s_count !== 2'd2) begin bad++; $display("FAIL bps_full_count: got %0d want 2", s_count); end
    total++; if (s_in_ready !== 1'b0) begin bad++; $display("FAIL bps_full_ready: got %b want 0", s_in_ready); end
    total++; if (s_out_data !== 32'hA) begin bad++; $display("FAIL bps_full_data: got %h want a", s_out_data); end
    s_in_valid = 0; s_out_ready = 1;
    #1;
    total++; if (s_in_ready !== 1'b0) begin bad++; $display("FAIL bps_ready_comb: got %b want 0", s_in_ready); end
    tick();
    total++; if (s_out_data !== 32'hB || s_count !== 2'd1) begin bad++; $display("FAIL bps_pop1: got %h/%0d want b/1", s_out_data, s_count); end
    total++; if (s_in_ready !== 1'b1) begin bad++; $display("FAIL bps_ready_back: got %b want 1", s_in_ready); end
    tick();
    total++; if (s_count !== 2'd0 || s_out_valid !== 1'b0) begin bad++; $display("FAIL bps_pop2: got %0d/%b want 0/0", s_count, s_out_valid); end
  endtask

  task automatic test_bp_noskid();
    n_out_ready = 0;
    n_in_valid = 1; n_in_data = 32'hC;
    tick();
    total++; if (n_in_ready !== 1'b0) begin bad++; $display("FAIL bpn_ready_low: got %b want 0", n_in_ready); end
    total++; if (n_count !== 2'd1 || n_out_data !== 32'hC) begin bad++; $display("FAIL bpn_hold: got %0d/%h want 1/c", n_count, n_out_data); end
    n_out_ready = 1; n_in_data = 32'hD;
    #1;
    total++; if (n_in_ready !== 1'b1) begin bad++; $display("FAIL bpn_ready_follow: got %b want 1", n_in_ready); end
    tick();
    total++; if (n_out_data !== 32'hD || n_count !== 2'd1) begin bad++; $display("FAIL bpn_swap: got %h/%0d want d/1", n_out_data, n_count); end
    n_in_valid = 0;
    tick();
    total++; if (n_count !== 2'd0) begin bad++; $display("FAIL bpn_drain: got %0d want 0", n_count); end
  endtask

  task automatic test_flush();
    s_out_ready = 0; n_out_ready = 0;
    s_in_valid = 1; s_in_data = 32'hE;
    n_in_valid = 1; n_in_data = 32'h11;
    tick();
    s_in_data = 32'hF; n_in_valid = 0;
    tick();
    total++; if (s_count !== 2'd2) begin bad++; $display("FAIL fl_full: got %0d want 2", s_count); end
    s_in_data = 32'h10; s_flush = 1;
    n_in_valid = 1; n_in_data = 32'h12; n_out_ready = 1; n_flush = 1;
    #1;
    total++; if (n_in_ready !== 1'b1) begin bad++; $display("FAIL fl_n_accept: got %b want 1", n_in_ready); end
    tick();
    s_flush = 0; s_in_valid = 0; n_flush = 0; n_in_valid = 0;
    total++; if (s_out_valid !== 1'b0 || s_count !== 2'd0) begin bad++; $display("FAIL fl_s_empty: got %b/%0d want 0/0", s_out_valid, s_count); end
    total++; if (s_out_data !== RV) begin bad++; $display("FAIL fl_s_data: got %h want %h", s_out_data, RV); end
    total++; if (s_in_ready !== 1'b1) begin bad++; $display("FAIL fl_s_ready: got %b want 1", s_in_ready); end
    total++; if (n_out_valid !== 1'b0 || n_out_data !== RV) begin bad++; $display("FAIL fl_n_empty: got %b/%h want 0/%h", n_out_valid, n_out_data, RV); end
    s_out_ready = 1;
    tick();
    total++; if (s_out_valid !== 1'b0 || s_out_data === 32'h10) begin bad++; $display("FAIL fl_s_dropped: got %b/%h want 0/%h", s_out_valid, s_out_data, RV); end
    total++; if (n_out_valid !== 1'b0 || n_out_data === 32'h12) begin bad++; $display("FAIL fl_n_dropped: got %b/%h want 0/%h", n_out_valid, n_out_data, RV); end
  endtask

  task automatic test_async_reset();
    s_out_ready = 0; s_in_valid = 1; s_in_data = 32'h21;
    n_out_ready = 0; n_in_valid = 1; n_in_data = 32'h22;
    tick();
    s_in_data = 32'h23;
    tick();
    s_in_valid = 0; n_in_valid = 0;
    total++; if (s_count !== 2'd2) begin bad++; $display("FAIL ar_pre: got %0d want 2", s_count); end
    #2;
    reset = 1'b1;
    #1;
    total++; if (s_out_valid !== 1'b0 || s_count !== 2'd0) begin bad++; $display("FAIL ar_s_state: got %b/%0d want 0/0", s_out_valid, s_count); end
    total++; if (s_out_data !== RV || s_in_ready !== 1'b1) begin bad++; $display("FAIL ar_s_out: got %h/%b want %h/1", s_out_data, s_in_ready, RV); end
    total++; if (n_out_valid !== 1'b0 || n_out_data !== RV) begin bad++; $display("FAIL ar_n_out: got %b/%h want 0/%h", n_out_valid, n_out_data, RV); end
    #1;
    reset = 1'b0;
    tick();
    total++; if (s_out_valid !== 1'b0 || n_out_valid !== 1'b0) begin bad++; $display("FAIL ar_after: got %b/%b want 0/0", s_out_valid, n_out_valid); end
  endtask

  task automatic test_random();
    logic [31:0] sq[$];
    logic [31:0] nq[$];
    logic [31:0] s_next, n_next, tmp;
    logic        s_hold, n_hold, s_pop, n_pop;
    s_next = 32'h100; n_next = 32'h100;
    for (int k = 0; k < 10000; k++) begin
      s_in_valid = 1'($urandom_range(0, 1)); s_out_ready = 1'($urandom_range(0, 1)); s_in_data = s_next;
      n_in_valid = 1'($urandom_range(0, 1)); n_out_ready = 1'($urandom_range(0, 1)); n_in_data = n_next;
      #2;
      s_pop = s_out_valid && s_out_ready;
      n_pop = n_out_valid && n_out_ready;
      if (s_pop) begin
        total++;
        if (sq.size() == 0) begin bad++; $display("FAIL rnd_s_extra: got %h want none", s_out_data); end
        else begin
          if (s_out_data !== sq[0]) begin bad++; $display("FAIL rnd_s_order: got %h want %h", s_out_data, sq[0]); end
          tmp = sq.pop_front();
        end
      end
      if (n_pop) begin
        total++;
        if (nq.size() == 0) begin bad++; $display("FAIL rnd_n_extra: got %h want none", n_out_data); end
        else begin
          if (n_out_data !== nq[0]) begin bad++; $display("FAIL rnd_n_order: got %h want %h", n_out_data, nq[0]); end
          tmp = nq.pop_front();
        end
      end
      if (s_in_valid && s_in_ready) begin sq.push_back(s_next); s_next++; end
      if (n_in_valid && n_in_ready) begin nq.push_back(n_next); n_next++; end
      s_hold = s_out_valid && !s_pop;
      n_hold = n_out_valid && !n_pop;
      tick();
      total++; if (s_hold && !s_out_valid) begin bad++; $display("FAIL rnd_s_drop: got %b want 1 at %0d", s_out_valid, k); end
      total++; if (n_hold && !n_out_valid) begin bad++; $display("FAIL rnd_n_drop: got %b want 1 at %0d", n_out_valid, k); end
      total++; if ({30'd0, s_count} !== 32'(sq.size())) begin bad++; $display("FAIL rnd_s_count: got %0d want %0d", s_count, sq.size()); end
      total++; if ({30'd0, n_count} !== 32'(nq.size())) begin bad++; $display("FAIL rnd_n_count: got %0d want %0d", n_count, nq.size()); end
    end
    s_in_valid = 0; n_in_valid = 0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_bp_skid();
    test_bp_noskid();
    test_flush();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised elastic pipeline register that separates two stages of the RV32IC core, such as IF/ID, ID/EX, EX/MEM and MEM/WB. It replaces the plain reset-to-zero stage register with a valid/ready handshake, so stalls propagate as back-pressure instead of global enables. It provides synchronous flush for branch and jump bubbles, and an optional 2-entry skid buffer so `in_ready` is driven from a flop. The payload is an opaque vector, normally a `PipelineReg` stage struct packed via `$bits`.

## Interface
- `WIDTH`, 32: payload width in bits; ≥1.
- `RESET_VALUE`, `'0`: payload value loaded on reset and on flush.
- `SKID`, 1: 1 selects a 2-entry buffer with registered `in_ready`; 0 selects a 1-entry buffer with combinational `in_ready`.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `flush`  in  1  synchronous bubble insertion; discards all held entries.
- `in_valid`  in  1  upstream presents `in_data`.
- `in_ready`  out  1  block accepts `in_data` this cycle.
- `in_data`  in  WIDTH  upstream payload.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  downstream consumes this cycle.
- `out_data`  out  WIDTH  payload of the oldest entry.
- `count`  out  2  occupancy, 0..2 (0..1 when SKID=0).

## Operation
- Handshake events: push = `in_valid && in_ready`; pop = `out_valid && out_ready`.
- Storage: `main` entry drives `out_data`; the `skid` entry exists only when SKID=1.
- States are EMPTY, HALF and FULL; FULL exists only when SKID=1. `count` encodes the state as 0, 1 or 2.
- EMPTY:
  - push: `main` ← `in_data`, go to HALF.
- HALF:
  - push without pop: `skid` ← `in_data`, go to FULL. When SKID=0 this cannot occur.
  - push with pop: `main` ← `in_data`, stay in HALF.
  - pop only: go to EMPTY; `main` keeps its stale value.
  - neither: hold.
- FULL:
  - pop: `main` ← `skid`, go to HALF.
  - no push is possible, because `in_ready`=0.
- `out_valid` = (state ≠ EMPTY).
- `in_ready`, SKID=1: registered, equal to (next state ≠ FULL).
- `in_ready`, SKID=0: `!out_valid || out_ready`.
- Flush has the highest priority. It sends the state to EMPTY and loads `main` and `skid` with RESET_VALUE. A push or pop occurring in the flush cycle is consumed and dropped.
- Flush with `in_valid` high: upstream sees the handshake complete, and the data is discarded.
- Payload is never modified, only stored and forwarded in order. No entry is ever duplicated or lost except on flush.

## Timing
- Reset, asynchronous: state EMPTY, `out_valid`=0, `count`=0, `out_data`=RESET_VALUE.
- `in_ready` after reset: 1 when SKID=1; for SKID=0 it follows the combinational formula, which also gives 1.
- Latency: a push in cycle N makes the data visible on `out_data` with `out_valid`=1 in cycle N+1.
- Throughput: 1 transfer per cycle while `out_ready`=1.
- Back-pressure when SKID=1: one further push is absorbed into `skid`, then `in_ready` drops on the next edge. `in_ready` never combinationally depends on `out_ready`.
- Back-pressure when SKID=0: `in_ready` combinationally follows `out_ready`.
- After flush in cycle N: `out_valid`=0 and `in_ready`=1 in cycle N+1.
- Reset deasserted mid-stream: no entries survive; upstream must re-present its data.

## Structure
- Package `PipelineReg` holds:
  - `stage_state_e` enum (EMPTY, HALF, FULL);
  - existing stage payload structs (e.g. `EX_STATE`), with `WIDTH` set to `$bits(PipelineReg::EX_STATE)`.
- One `generate` branch on SKID. No sub-module: the entry registers are trivial flops.
- Per-stage instantiation replaces the old per-stage reset-only registers.

## Test plan
- Reset, then stream 0x00000001..0x00000008 with `out_ready`=1: outputs appear one cycle after each push, in order, at 1/cycle, with `count` toggling 0→1 and staying 1.
- SKID=1, push 0xA, 0xB with `out_ready`=0: `count`=2, `in_ready`=0, `out_data`=0xA. Raise `out_ready`: 0xA then 0xB pop, and `in_ready` returns to 1 one edge after the first pop.
- SKID=0, `out_ready`=0 holding 0xC: `in_ready`=0 in the same cycle. Raise `out_ready` together with push 0xD: 0xC pops, 0xD is loaded, `count` stays 1.
- FULL state (0xE, 0xF), assert `flush` with `in_valid`=1 and `in_data`=0x10: next cycle `out_valid`=0, `count`=0, `out_data`=RESET_VALUE, `in_ready`=1; 0x10 never appears.
- Assert `reset` asynchronously mid-stream, between clock edges: outputs go to reset values immediately, without waiting for the clock edge.
- Random `in_valid`/`out_ready` for 10k cycles, both SKID settings: the scoreboard confirms in-order, lossless delivery, and `out_valid` never drops without a pop or flush.
